mismatch_logger: RTL and testbench

Downstream consumer of the pipelined compare stage. Accepts one compare result per clock: a mismatch flag plus the 32-bit counter value that produced it. Keeps running match/mismatch statistics and buffers the tags of mismatching samples in a small FIFO, which a host or testbench drains over a valid/ready port. Lost captures are counted and flagged rather than silently discarded.

---
 rtl/mismatch_logger.sv | 116 +++++++++++
 tb/tb_mismatch_logger.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mismatch_logger.sv
// mismatch_logger: collects compare results, keeps saturating match/mismatch/drop
// statistics and buffers mismatching tags in a FIFO drained over valid/ready.
module mismatch_logger #(
    parameter  int DEPTH = 8,
    parameter  int TAG_W = 32,
    parameter  int CNT_W = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_mismatch,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [LW-1:0]    level,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow
);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] mism_q, mism_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             ovf_q, ovf_d;

    logic full, empty, pop, smp_mm, push, drop, wr_en;

    // Event decode; full/empty come from the occupancy count, never pointer compare.
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        full   = (level_q == LW'(DEPTH));
        empty  = (level_q == '0);
        pop    = ~empty & out_ready;
        smp_mm = in_valid & in_mismatch;
        push   = smp_mm & (~full | pop);
        drop   = smp_mm & full & ~pop;
        wr_en  = push & ~clr;
    end

    // Next-state for pointers, occupancy, saturating counters and sticky overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        match_d  = match_q;
        mism_d   = mism_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        if (clr) begin
            // clear wins over the sample and any pop presented this cycle
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            match_d  = '0;
            mism_d   = '0;
            drop_d   = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (in_valid & ~in_mismatch & (match_q != '1)) match_d = match_q + CNT_W'(1);
            if (smp_mm & (mism_q != '1))                   mism_d  = mism_q + CNT_W'(1);
            if (drop & (drop_q != '1))                     drop_d  = drop_q + CNT_W'(1);
            if (drop)                                      ovf_d   = 1'b1;
        end
    end

    // Control/status registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            match_q  <= '0;
            mism_q   <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            match_q  <= match_d;
            mism_q   <= mism_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    // Tag storage has no reset; contents are only visible behind out_valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_tag;
    end

    assign out_valid    = ~empty;
    assign out_tag      = mem_q[rd_ptr_q];
    assign level        = level_q;
    assign match_cnt    = match_q;
    assign mismatch_cnt = mism_q;
    assign drop_cnt     = drop_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_mismatch_logger.sv
// Bench: two instances (32-bit and 4-bit counters) share one stimulus stream and
// are compared after every edge against a queue-based reference model.
module tb_mismatch_logger;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_mismatch = 1'b0;
    logic [31:0] in_tag = '0;
    logic        out_ready = 1'b0;

    logic          a_vld, b_vld, a_ovf, b_ovf;
    logic [31:0]   a_tag, b_tag;
    logic [LW-1:0] a_lvl, b_lvl;
    logic [31:0]   a_mc, a_mm, a_dc;
    logic [3:0]    b_mc, b_mm, b_dc;

    int total = 0;
    int bad   = 0;

    // reference model: true (unsaturated) counts and a tag queue
    logic [31:0] q[$];
    longint      m_match, m_mism, m_drop;
    bit          m_ovf;

    always #5 clk = ~clk;

    mismatch_logger #(.DEPTH(DEPTH), .TAG_W(32), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_mismatch(in_mismatch),
        .in_tag(in_tag), .out_valid(a_vld), .out_ready(out_ready), .out_tag(a_tag),
        .level(a_lvl), .match_cnt(a_mc), .mismatch_cnt(a_mm), .drop_cnt(a_dc), .overflow(a_ovf));

    mismatch_logger #(.DEPTH(DEPTH), .TAG_W(32), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_mismatch(in_mismatch),
        .in_tag(in_tag), .out_valid(b_vld), .out_ready(out_ready), .out_tag(b_tag),
        .level(b_lvl), .match_cnt(b_mc), .mismatch_cnt(b_mm), .drop_cnt(b_dc), .overflow(b_ovf));

    function automatic logic [63:0] sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_match = 0; m_mism = 0; m_drop = 0; m_ovf = 0;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, " a.level"},  64'(a_lvl), 64'(q.size()));
        chk({ctx, " b.level"},  64'(b_lvl), 64'(q.size()));
        chk({ctx, " a.valid"},  64'(a_vld), 64'(q.size() != 0));
        chk({ctx, " b.valid"},  64'(b_vld), 64'(q.size() != 0));
        chk({ctx, " a.ovf"},    64'(a_ovf), 64'(m_ovf));
        chk({ctx, " b.ovf"},    64'(b_ovf), 64'(m_ovf));
        chk({ctx, " a.match"},  64'(a_mc),  sat(m_match, 32));
        chk({ctx, " a.mism"},   64'(a_mm),  sat(m_mism, 32));
        chk({ctx, " a.drop"},   64'(a_dc),  sat(m_drop, 32));
        chk({ctx, " b.match"},  64'(b_mc),  sat(m_match, 4));
        chk({ctx, " b.mism"},   64'(b_mm),  sat(m_mism, 4));
        chk({ctx, " b.drop"},   64'(b_dc),  sat(m_drop, 4));
        if (q.size() != 0) begin
            chk({ctx, " a.tag"}, 64'(a_tag), 64'(q[0]));
            chk({ctx, " b.tag"}, 64'(b_tag), 64'(q[0]));
        end
    endtask

    // one clock: drive inputs, advance the model, check #1 after the edge
    task automatic step(input string ctx, input bit v, input bit mm, input logic [31:0] tg,
                        input bit rdy, input bit c);
        bit pop;
        in_valid = v; in_mismatch = mm; in_tag = tg; out_ready = rdy; clr = c;
        if (c) begin
            model_reset();
        end else begin
            pop = rdy && (q.size() != 0);
            if (v && !mm) m_match++;
            if (v && mm) m_mism++;
            if (pop) void'(q.pop_front());
            if (v && mm) begin
                if (q.size() < DEPTH) q.push_back(tg);
                else begin m_drop++; m_ovf = 1; end
            end
        end
        @(posedge clk);
        #1;
        check_all(ctx);
        in_valid = 0; in_mismatch = 0; out_ready = 0; clr = 0;
    endtask

    task automatic drain(input string ctx);
        for (int i = 0; i < DEPTH + 1; i++) step(ctx, 0, 0, 32'h0, 1, 0);
    endtask

    initial begin
        model_reset();
        // reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset");

        // idle matches
        for (int i = 0; i < 10; i++) step("match", 1, 0, 32'(i), 0, 0);
        chk("idle a.match=10", 64'(a_mc), 64'd10);
        chk("idle a.level=0",  64'(a_lvl), 64'd0);

        // capture order
        step("cap", 1, 1, 32'h00000005, 0, 0);
        step("cap", 1, 1, 32'h00000105, 0, 0);
        step("cap", 1, 1, 32'h01020304, 0, 0);
        chk("cap level=3", 64'(a_lvl), 64'd3);
        chk("cap head", 64'(a_tag), 64'h5);
        drain("cap_drain");
        chk("cap empty", 64'(a_vld), 64'd0);

        // overflow: 10 mismatches into 8 entries
        step("clr1", 0, 0, 32'h0, 0, 1);
        for (int i = 0; i < 10; i++) step("ovf", 1, 1, 32'(i), 0, 0);
        chk("ovf level=8", 64'(a_lvl), 64'd8);
        chk("ovf drop=2",  64'(a_dc),  64'd2);
        chk("ovf flag",    64'(a_ovf), 64'd1);
        chk("ovf mism=10", 64'(a_mm),  64'd10);
        drain("ovf_drain");

        // full with simultaneous pop
        step("clr2", 0, 0, 32'h0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 1, 32'(16 + i), 0, 0);
        step("fullpop", 1, 1, 32'hAA, 1, 0);
        chk("fullpop level=8", 64'(a_lvl), 64'd8);
        chk("fullpop drop=0",  64'(a_dc),  64'd0);
        for (int i = 0; i < DEPTH - 1; i++) step("fp_drain", 0, 0, 32'h0, 1, 0);
        chk("fullpop last=AA", 64'(a_tag), 64'hAA);
        drain("fp_drain2");

        // clr mid-stream with level=5 and overflow set
        for (int i = 0; i < DEPTH + 1; i++) step("pre5", 1, 1, 32'(100 + i), 0, 0);
        for (int i = 0; i < 3; i++) step("pre5pop", 0, 0, 32'h0, 1, 0);
        chk("pre5 level=5", 64'(a_lvl), 64'd5);
        step("clr_mid", 1, 1, 32'hDEAD, 1, 1);
        chk("clr_mid level=0", 64'(a_lvl), 64'd0);
        chk("clr_mid ovf=0",   64'(a_ovf), 64'd0);

        // async reset in the middle of a cycle
        for (int i = 0; i < DEPTH + 2; i++) step("pre_rst", 1, i[0], 32'(200 + i), 0, 0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;

        // saturation of the 4-bit instance
        step("clr3", 0, 0, 32'h0, 0, 1);
        for (int i = 0; i < 20; i++) step("sat", 1, 0, 32'(i), 0, 0);
        chk("sat b.match=15", 64'(b_mc), 64'd15);
        chk("sat a.match=20", 64'(a_mc), 64'd20);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), $urandom,
                 bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 60) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
